// File: rtl/mux_pipe_n1_pkg.sv
// Shared types and sizing helpers for the pipelined N:1 mux and its regfile read-path wrapper.
package mux_pkg;

    typedef struct packed {
        logic valid;
        logic err;
    } stage_ctl_t;

    function automatic int stages_f(input int levels, input int reg_every);
        return (levels + reg_every - 1) / reg_every;
    endfunction

    function automatic int min_f(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/mux_pipe_n1_if.sv
// Valid/ready bus of the pipelined mux: channel bundle and select in, selected channel out.
interface mux_pipe_n1_if #(
    parameter int WIDTH = 64,
    parameter int N     = 32
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_err;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_err, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_err, out_valid
    );
endinterface

// File: rtl/mux_pipe_n1_stage.sv
// One pipeline stage: LV rows of 2:1 muxes followed by the stage register and its load logic.
module mux_pipe_stage
    import mux_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int IN_CH    = 4,
    parameter int LV       = 2,
    parameter int SEL_IN_W = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [IN_CH*WIDTH-1:0]                  in_data,
    input  logic [SEL_IN_W-1:0]                     in_sel,
    input  stage_ctl_t                              in_ctl,
    input  logic                                    load_next,
    output logic                                    load,
    output logic [(IN_CH>>LV)*WIDTH-1:0]            out_data,
    output logic [((SEL_IN_W>LV)?(SEL_IN_W-LV):1)-1:0] out_sel,
    output stage_ctl_t                              out_ctl
);
    localparam int OUT_CH = IN_CH >> LV;
    localparam int SOW    = (SEL_IN_W > LV) ? (SEL_IN_W - LV) : 1;

    logic [WIDTH-1:0]        lvl_s [LV+1][IN_CH];
    logic [OUT_CH*WIDTH-1:0] mux_s;
    logic [SOW-1:0]          upper_s;
    logic                    load_s;
    stage_ctl_t              ctl_r;
    logic [OUT_CH*WIDTH-1:0] data_r;
    logic [SOW-1:0]          sel_r;

    // Mux rows: each row halves the live channel count using one select bit, LSB first
    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            for (int c = 0; c < IN_CH; c++) begin
                lvl_s[l][c] = '0;
            end
        end
        for (int c = 0; c < IN_CH; c++) begin
            lvl_s[0][c] = in_data[c*WIDTH +: WIDTH];
        end
        for (int l = 0; l < LV; l++) begin
            for (int c = 0; c < IN_CH/2; c++) begin
                lvl_s[l+1][c] = in_sel[l] ? lvl_s[l][2*c+1] : lvl_s[l][2*c];
            end
        end
        mux_s = '0;
        for (int c = 0; c < OUT_CH; c++) begin
            mux_s[c*WIDTH +: WIDTH] = lvl_s[LV][c];
        end
    end

    // Select bits this stage does not consume travel on to the next stage
    if (SEL_IN_W > LV) begin : g_upper
        assign upper_s = in_sel[SEL_IN_W-1:LV];
    end else begin : g_no_upper
        assign upper_s = '0;
    end

    assign load_s = !ctl_r.valid | load_next;

    // Stage register: advance when empty or when downstream takes the current item
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_r  <= '0;
            data_r <= '0;
            sel_r  <= '0;
        end else if (load_s) begin
            ctl_r  <= '{valid: in_ctl.valid, err: in_ctl.valid & in_ctl.err};
            data_r <= in_ctl.valid ? mux_s : '0;
            sel_r  <= in_ctl.valid ? upper_s : '0;
        end
    end

    assign load     = load_s;
    assign out_data = data_r;
    assign out_sel  = sel_r;
    assign out_ctl  = ctl_r;

endmodule

// File: rtl/mux_pipe_n1.sv
// Parametrised pipelined N:1 mux with valid/ready handshake and out-of-range select flag.
module mux_pipe_n1
    import mux_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int N         = 32,
    parameter int REG_EVERY = 2
) (
    input  logic       clk,
    input  logic       reset,
    mux_pipe_n1_if.slave bus
);
    localparam int SEL_W  = $clog2(N);
    localparam int LEVELS = SEL_W;
    localparam int STAGES = stages_f(LEVELS, REG_EVERY);
    localparam int NP     = 1 << LEVELS;
    localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

    logic [NP*WIDTH-1:0] pad_s;
    logic                err_s;

    // Channels above N read as zero, so an out-of-range select yields zero data
    always_comb begin
        pad_s = '0;
        pad_s[N*WIDTH-1:0] = bus.in_data;
    end

    assign err_s = ({1'b0, bus.in_sel} >= N_L);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LV     = min_f(REG_EVERY, LEVELS - s*REG_EVERY);
        localparam int IN_CH  = NP >> (s*REG_EVERY);
        localparam int OUT_CH = IN_CH >> LV;
        localparam int SIW    = LEVELS - s*REG_EVERY;
        localparam int SOW    = (SIW > LV) ? (SIW - LV) : 1;

        logic [IN_CH*WIDTH-1:0]  src_data_s;
        logic [SIW-1:0]          src_sel_s;
        stage_ctl_t              src_ctl_s;
        logic                    next_load_s;
        logic                    load_s;
        logic [OUT_CH*WIDTH-1:0] data_s;
        logic [SOW-1:0]          sel_s;
        stage_ctl_t              ctl_s;

        if (s == 0) begin : g_head
            assign src_data_s = pad_s;
            assign src_sel_s  = bus.in_sel;
            assign src_ctl_s  = '{valid: bus.in_valid, err: err_s};
        end else begin : g_link
            assign src_data_s = g_stage[s-1].data_s;
            assign src_sel_s  = g_stage[s-1].sel_s;
            assign src_ctl_s  = g_stage[s-1].ctl_s;
        end

        // Ready ripples back combinationally from the consumer
        if (s == STAGES-1) begin : g_tail
            assign next_load_s = bus.out_ready;
        end else begin : g_mid
            assign next_load_s = g_stage[s+1].load_s;
        end

        mux_pipe_stage #(
            .WIDTH   (WIDTH),
            .IN_CH   (IN_CH),
            .LV      (LV),
            .SEL_IN_W(SIW)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .in_data  (src_data_s),
            .in_sel   (src_sel_s),
            .in_ctl   (src_ctl_s),
            .load_next(next_load_s),
            .load     (load_s),
            .out_data (data_s),
            .out_sel  (sel_s),
            .out_ctl  (ctl_s)
        );
    end

    assign bus.in_ready  = g_stage[0].load_s;
    assign bus.out_data  = g_stage[STAGES-1].data_s;
    assign bus.out_valid = g_stage[STAGES-1].ctl_s.valid;
    assign bus.out_err   = g_stage[STAGES-1].ctl_s.err;

endmodule

// File: tb/tb_mux_pipe_n1.sv
// Randomised bench for mux_pipe_n1: three configurations checked against a queue-based reference model.
module tb_mux_pipe_n1;

    localparam int STA = 2;  // N=16: 4 levels, 2 per stage
    localparam int STB = 3;  // N=32: 5 levels
    localparam int STC = 3;  // N=20: 5 levels

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
        bit          exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   exact_mode = 1'b1;

    exp_t qa[$], qb[$], qc[$];
    int   occa = 0, occb = 0, occc = 0;
    logic holda = 1'b0, holdb = 1'b0, holdc = 1'b0;
    logic [63:0] hda = '0, hdb = '0, hdc = '0;
    logic hea = 1'b0, heb = 1'b0, hec = 1'b0;

    mux_pipe_n1_if #(.WIDTH(1),  .N(16)) ifa ();
    mux_pipe_n1_if #(.WIDTH(64), .N(32)) ifb ();
    mux_pipe_n1_if #(.WIDTH(8),  .N(20)) ifc ();

    mux_pipe_n1 #(.WIDTH(1),  .N(16), .REG_EVERY(2)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    mux_pipe_n1 #(.WIDTH(64), .N(32), .REG_EVERY(2)) dut_b (.clk(clk), .reset(rst), .bus(ifb));
    mux_pipe_n1 #(.WIDTH(8),  .N(20), .REG_EVERY(2)) dut_c (.clk(clk), .reset(rst), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic e);
        exp_t r;
        r.data  = d;
        r.err   = e;
        r.cyc   = 0;
        r.exact = exact_mode;
        return r;
    endfunction

    // Reference model step: ready from occupancy, in-order scoreboard, latency and stall stability
    task automatic mon_step(input string tag, input int stages,
                            input logic iv, input logic ir, input logic ov, input logic orr,
                            input logic [63:0] od, input logic oe, input exp_t nx,
                            ref exp_t q[$], ref int occ, ref logic hold,
                            ref logic [63:0] hd, ref logic he);
        exp_t e;
        check({tag, "_in_ready"}, ir, (occ < stages) || orr);
        if (occ == 0) check({tag, "_idle_valid"}, ov, 1'b0);
        if (hold) begin
            check({tag, "_hold_valid"}, ov, 1'b1);
            check({tag, "_hold_data"}, od, hd);
            check({tag, "_hold_err"}, oe, he);
        end
        if (ov && orr) begin
            check({tag, "_out_expected"}, q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                occ--;
                check({tag, "_data"}, od, e.data);
                check({tag, "_err"}, oe, e.err);
                if (e.exact) check({tag, "_latency"}, cyc - e.cyc, stages);
                else check({tag, "_latency_min"}, (cyc - e.cyc) >= stages, 1'b1);
            end
        end
        if (iv && ir) begin
            e = nx;
            e.cyc = cyc;
            q.push_back(e);
            occ++;
        end
        hold = ov && !orr;
        hd   = od;
        he   = oe;
    endtask

    // Observe all three pipelines half a cycle away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            occa = 0; occb = 0; occc = 0;
            holda = 1'b0; holdb = 1'b0; holdc = 1'b0;
        end else begin
            mon_step("A", STA, ifa.in_valid, ifa.in_ready, ifa.out_valid, ifa.out_ready,
                     64'(ifa.out_data), ifa.out_err,
                     mk(64'((ifa.in_data >> ifa.in_sel) & 16'h1), ({1'b0, ifa.in_sel} >= 5'd16)),
                     qa, occa, holda, hda, hea);
            mon_step("B", STB, ifb.in_valid, ifb.in_ready, ifb.out_valid, ifb.out_ready,
                     ifb.out_data, ifb.out_err,
                     mk(64'(ifb.in_data >> (int'(ifb.in_sel) * 64)), ({1'b0, ifb.in_sel} >= 6'd32)),
                     qb, occb, holdb, hdb, heb);
            mon_step("C", STC, ifc.in_valid, ifc.in_ready, ifc.out_valid, ifc.out_ready,
                     64'(ifc.out_data), ifc.out_err,
                     mk((int'(ifc.in_sel) < 20) ? 64'((ifc.in_data >> (int'(ifc.in_sel) * 8)) & 160'hFF) : 64'h0,
                        (int'(ifc.in_sel) >= 20)),
                     qc, occc, holdc, hdc, hec);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (qa.size() + qb.size() + qc.size()) != 0; i++) step();
        check("drain_timeout", qa.size() + qb.size() + qc.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("A_rst_valid", ifa.out_valid, 1'b0);
        check("A_rst_ready", ifa.in_ready, 1'b1);
        check("A_rst_data", 64'(ifa.out_data), 64'h0);
        check("B_rst_valid", ifb.out_valid, 1'b0);
        check("B_rst_ready", ifb.in_ready, 1'b1);
        check("B_rst_data", ifb.out_data, 64'h0);
        check("B_rst_err", ifb.out_err, 1'b0);
        check("C_rst_valid", ifc.out_valid, 1'b0);
        check("C_rst_ready", ifc.in_ready, 1'b1);
        check("C_rst_err", ifc.out_err, 1'b0);
    endtask

    initial begin
        ifa.in_data = '0; ifa.in_sel = '0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_data = '0; ifb.in_sel = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b1;
        ifc.in_data = '0; ifc.in_sel = '0; ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
        for (int c = 0; c < 32; c++) ifb.in_data[c*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(c);
        for (int c = 0; c < 20; c++) ifc.in_data[c*8 +: 8] = 8'($urandom);

        #1 rst = 1'b1;
        #2 check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        step();

        // Scenario 1: walk every select over a fixed pattern, then its complement
        exact_mode = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            ifa.in_data = (pass == 0) ? 16'h39CA : ~16'h39CA;
            for (int i = 0; i < 16; i++) begin
                ifa.in_valid = 1'b1;
                ifa.in_sel   = 4'(i);
                step();
            end
            ifa.in_valid = 1'b0;
            repeat (4) step();
        end

        // Scenario 2 and 3: random selects with gaps, consumer always ready
        ifc.in_sel = 5'd19; ifc.in_valid = 1'b1; step();
        ifc.in_sel = 5'd20; step();
        ifc.in_sel = 5'd31; step();
        ifc.in_sel = 5'd3;  step();
        for (int i = 0; i < 40; i++) begin
            ifb.in_valid = ($urandom_range(0, 3) != 0);
            ifb.in_sel   = 5'($urandom_range(0, 31));
            ifc.in_valid = ($urandom_range(0, 3) != 0);
            ifc.in_sel   = 5'($urandom_range(0, 31));
            step();
        end
        ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
        wait_drain();

        // Scenario 4: consumer stalls five cycles while the producer keeps streaming
        exact_mode = 1'b0;
        ifb.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 5) ifb.out_ready = 1'b1;
            ifb.in_valid = 1'b1;
            ifb.in_sel   = 5'($urandom_range(0, 31));
            step();
        end
        ifb.in_valid = 1'b0;
        wait_drain();

        // Scenario 5: two items separated by a bubble, consumer stalled
        ifb.out_ready = 1'b0;
        ifb.in_valid = 1'b1; ifb.in_sel = 5'd7;  step();
        ifb.in_valid = 1'b0;                     step();
        ifb.in_valid = 1'b1; ifb.in_sel = 5'd22; step();
        ifb.in_valid = 1'b0;
        repeat (3) step();
        check("B_bubble_out_valid", ifb.out_valid, 1'b1);
        check("B_bubble_in_ready", ifb.in_ready, 1'b1);
        ifb.in_valid = 1'b1; ifb.in_sel = 5'd13; step();
        check("B_full_in_ready", ifb.in_ready, 1'b0);
        ifb.in_valid = 1'b0;
        repeat (2) step();
        ifb.out_ready = 1'b1;
        wait_drain();

        // Scenario 6: asynchronous reset with two items in flight
        exact_mode = 1'b1;
        ifb.in_valid = 1'b1; ifb.in_sel = 5'd9;  step();
        ifb.in_sel = 5'd17; step();
        ifb.in_valid = 1'b0; step();
        check("B_pre_reset_valid", ifb.out_valid, 1'b1);
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        ifb.in_valid = 1'b1; ifb.in_sel = 5'd5; step();
        ifb.in_valid = 1'b0;
        wait_drain();
        check("B_occupancy_end", occb, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
